// File: rtl/gs_cmd_decoder.sv
`default_nettype none
// ==== gs_cmd_decoder : assembles SET_FB/LINE/FILL command words, dispatches to engines ====
// ==== optional GS_CMD_TIMEOUT_EN: abort a stalled partial command      rev 1.0        ====
module gs_cmd_decoder #(
  parameter int COORD_W  = 16,
  parameter int ADDR_W   = 24,
  parameter int SIZE_W   = 10,
  parameter int RST_FB_W = 640,
  parameter int RST_FB_H = 480,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [15:0]               i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic signed [COORD_W-1:0] o_x1,
  output logic signed [COORD_W-1:0] o_y1,
  output logic signed [COORD_W-1:0] o_x2,
  output logic signed [COORD_W-1:0] o_y2,
  output logic [15:0]               o_color,
  output logic                      o_line_start,
  output logic                      o_fill_start,
  input  logic                      i_busy,
  output logic [ADDR_W-1:0]         o_fb_addr,
  output logic [SIZE_W-1:0]         o_fb_width,
  output logic [SIZE_W-1:0]         o_fb_height,
  output logic                      o_err,
  input  logic                      i_err_clr
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_SETFB = 4'd1;
  localparam logic [3:0] OP_LINE  = 4'd2;
  localparam logic [3:0] OP_FILL  = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_DISPATCH = 2'd2,
    S_GUARD    = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  op_q, op_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic                        guard_q, guard_d;
  logic [15:0]                 sh_q [5];
  logic [15:0]                 sh_d [5];
  logic                        ready_q, ready_d;
  logic signed [COORD_W-1:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [15:0]                 color_q, color_d;
  logic                        line_start_q, line_start_d;
  logic                        fill_start_q, fill_start_d;
  logic [ADDR_W-1:0]           fb_addr_q, fb_addr_d;
  logic [SIZE_W-1:0]           fb_w_q, fb_w_d, fb_h_q, fb_h_d;
  logic                        err_q, err_d;
  logic                        err_set;
  logic                        accept;
  logic [2:0]                  last_idx;

`ifdef GS_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]            tmo_q, tmo_d;
`else
  logic                        unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  assign accept   = i_valid & ready_q;
  assign last_idx = (op_q == OP_SETFB) ? 3'd3 : 3'd4;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    guard_d      = guard_q;
    sh_d         = sh_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    x2_d         = x2_q;
    y2_d         = y2_q;
    color_d      = color_q;
    fb_addr_d    = fb_addr_q;
    fb_w_d       = fb_w_q;
    fb_h_d       = fb_h_q;
    line_start_d = 1'b0;
    fill_start_d = 1'b0;
    err_set      = 1'b0;
`ifdef GS_CMD_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = i_data[15:12];
          cnt_d = 3'd0;
`ifdef GS_CMD_TIMEOUT_EN
          tmo_d = '0;
`endif
          case (i_data[15:12])
            OP_NOP:                     state_d = S_IDLE;
            OP_SETFB, OP_LINE, OP_FILL: state_d = S_PAYLOAD;
            default:                    err_set = 1'b1;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          for (int i = 0; i < 5; i++) begin
            if (cnt_q == 3'(i)) sh_d[i] = i_data;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_idx) state_d = S_DISPATCH;
`ifdef GS_CMD_TIMEOUT_EN
          tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          // Stalled too long: drop the partial command without dispatching it.
          err_set = 1'b1;
          state_d = S_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end

      S_DISPATCH: begin
        // The framebuffer and engine operands only change while no engine is running.
        if (!i_busy) begin
          if (op_q == OP_SETFB) begin
            fb_addr_d = ADDR_W'({sh_q[0][7:0], sh_q[1]});
            fb_w_d    = sh_q[2][SIZE_W-1:0];
            fb_h_d    = sh_q[3][SIZE_W-1:0];
          end else begin
            x1_d         = COORD_W'(signed'(sh_q[0]));
            y1_d         = COORD_W'(signed'(sh_q[1]));
            x2_d         = COORD_W'(signed'(sh_q[2]));
            y2_d         = COORD_W'(signed'(sh_q[3]));
            color_d      = sh_q[4];
            line_start_d = (op_q == OP_LINE);
            fill_start_d = (op_q == OP_FILL);
          end
          guard_d = 1'b0;
          state_d = S_GUARD;
        end
      end

      S_GUARD: begin
        if (guard_q) state_d = S_IDLE;
        else         guard_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_PAYLOAD);
    // A new error wins over a simultaneous clear.
    err_d   = err_set | (err_q & ~i_err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      cnt_q        <= 3'd0;
      guard_q      <= 1'b0;
      for (int i = 0; i < 5; i++) sh_q[i] <= 16'h0000;
      ready_q      <= 1'b0;
      x1_q         <= '0;
      y1_q         <= '0;
      x2_q         <= '0;
      y2_q         <= '0;
      color_q      <= 16'h0000;
      line_start_q <= 1'b0;
      fill_start_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_w_q       <= SIZE_W'(RST_FB_W);
      fb_h_q       <= SIZE_W'(RST_FB_H);
      err_q        <= 1'b0;
`ifdef GS_CMD_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      guard_q      <= guard_d;
      sh_q         <= sh_d;
      ready_q      <= ready_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      x2_q         <= x2_d;
      y2_q         <= y2_d;
      color_q      <= color_d;
      line_start_q <= line_start_d;
      fill_start_q <= fill_start_d;
      fb_addr_q    <= fb_addr_d;
      fb_w_q       <= fb_w_d;
      fb_h_q       <= fb_h_d;
      err_q        <= err_d;
`ifdef GS_CMD_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign o_ready      = ready_q;
  assign o_x1         = x1_q;
  assign o_y1         = y1_q;
  assign o_x2         = x2_q;
  assign o_y2         = y2_q;
  assign o_color      = color_q;
  assign o_line_start = line_start_q;
  assign o_fill_start = fill_start_q;
  assign o_fb_addr    = fb_addr_q;
  assign o_fb_width   = fb_w_q;
  assign o_fb_height  = fb_h_q;
  assign o_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gs_cmd_decoder.sv
`default_nettype none
// ==== tb_gs_cmd_decoder : scoreboard bench for gs_cmd_decoder   rev 1.0 ====
module tb_gs_cmd_decoder;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        i_data = 16'h0000;
  logic               i_valid = 1'b0;
  logic               i_busy = 1'b0;
  logic               i_err_clr = 1'b0;
  logic               o_ready, o_line_start, o_fill_start, o_err;
  logic signed [15:0] o_x1, o_y1, o_x2, o_y2;
  logic [15:0]        o_color;
  logic [23:0]        o_fb_addr;
  logic [9:0]         o_fb_width, o_fb_height;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    bit          fill;
    logic [15:0] x1, y1, x2, y2, c;
    int          at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gs_cmd_decoder #(
    .COORD_W(16), .ADDR_W(24), .SIZE_W(10),
    .RST_FB_W(640), .RST_FB_H(480), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_x1(o_x1), .o_y1(o_y1), .o_x2(o_x2), .o_y2(o_y2),
    .o_color(o_color), .o_line_start(o_line_start), .o_fill_start(o_fill_start),
    .i_busy(i_busy), .o_fb_addr(o_fb_addr), .o_fb_width(o_fb_width),
    .o_fb_height(o_fb_height), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every start pulse must match the oldest outstanding command.
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (o_line_start || o_fill_start)) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_start", {30'h0, o_line_start, o_fill_start}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk_eq("line_start", {31'h0, o_line_start}, {31'h0, !e.fill});
        chk_eq("fill_start", {31'h0, o_fill_start}, {31'h0, e.fill});
        chk_eq("x1", {16'h0, o_x1}, {16'h0, e.x1});
        chk_eq("y1", {16'h0, o_y1}, {16'h0, e.y1});
        chk_eq("x2", {16'h0, o_x2}, {16'h0, e.x2});
        chk_eq("y2", {16'h0, o_y2}, {16'h0, e.y2});
        chk_eq("color", {16'h0, o_color}, {16'h0, e.c});
        if (e.at >= 0) chk_eq("latency", cyc, e.at);
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    i_data  = w;
    i_valid = 1'b1;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk_eq("ready_wait", {31'h0, o_ready}, 32'h1);
    last_acc = cyc + 1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send_draw(input logic [3:0] op, input logic [15:0] x1, input logic [15:0] y1,
                           input logic [15:0] x2, input logic [15:0] y2, input logic [15:0] c,
                           input bit gap, input bit timed);
    exp_t ex;
    send_word({op, 12'h000}, gap);
    send_word(x1, gap);
    send_word(y1, gap);
    send_word(x2, gap);
    send_word(y2, gap);
    send_word(c, gap);
    ex.fill = (op == 4'd3);
    ex.x1 = x1; ex.y1 = y1; ex.x2 = x2; ex.y2 = y2; ex.c = c;
    ex.at = timed ? last_acc + 1 : -1;
    sb.push_back(ex);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain", sb.size(), 32'h0);
  endtask

  task automatic check_reset_state(input string tag);
    chk_eq({tag, "_ready"}, {31'h0, o_ready}, 32'h0);
    chk_eq({tag, "_fb_addr"}, {8'h0, o_fb_addr}, 32'h0);
    chk_eq({tag, "_fb_w"}, {22'h0, o_fb_width}, 32'd640);
    chk_eq({tag, "_fb_h"}, {22'h0, o_fb_height}, 32'd480);
    chk_eq({tag, "_err"}, {31'h0, o_err}, 32'h0);
    chk_eq({tag, "_x1"}, {16'h0, o_x1}, 32'h0);
    chk_eq({tag, "_color"}, {16'h0, o_color}, 32'h0);
    chk_eq({tag, "_starts"}, {30'h0, o_line_start, o_fill_start}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("ready_after_rst", {31'h0, o_ready}, 32'h1);

    // Basic LINE with negative coordinate.
    send_draw(4'd2, 16'd100, 16'd20, 16'd40, 16'hFFF6, 16'hF800, 1'b0, 1'b1);
    wait_drain();
    chk_eq("hold_y2", {16'h0, o_y2}, 32'h0000FFF6);

    // SET_FB
    send_word(16'h1000, 1'b0);
    send_word(16'h0012, 1'b0);
    send_word(16'h3456, 1'b0);
    send_word(16'd320, 1'b0);
    send_word(16'd240, 1'b0);
    repeat (4) @(negedge clk);
    chk_eq("fb_addr", {8'h0, o_fb_addr}, 32'h00123456);
    chk_eq("fb_w", {22'h0, o_fb_width}, 32'd320);
    chk_eq("fb_h", {22'h0, o_fb_height}, 32'd240);

    // FILL held off by busy.
    i_busy = 1'b1;
    send_draw(4'd3, 16'd0, 16'd0, 16'd9, 16'd9, 16'h07E0, 1'b0, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk_eq("busy_ready", {31'h0, o_ready}, 32'h0);
      chk_eq("busy_fill", {31'h0, o_fill_start}, 32'h0);
      chk_eq("busy_hold_x2", {16'h0, o_x2}, 32'd40);
    end
    i_busy = 1'b0;
    @(negedge clk);
    chk_eq("fill_on_busy_fall", {31'h0, o_fill_start}, 32'h1);
    wait_drain();
    chk_eq("fill_color", {16'h0, o_color}, 32'h000007E0);

    // Illegal opcode with simultaneous clear, NOP, then normal decode.
    i_err_clr = 1'b1;
    send_word(16'h7000, 1'b0);
    i_err_clr = 1'b0;
    chk_eq("err_set_vs_clr", {31'h0, o_err}, 32'h1);
    send_word(16'h0000, 1'b0);
    chk_eq("nop_keeps_err", {31'h0, o_err}, 32'h1);
    send_draw(4'd2, 16'hFFFD, 16'd7, 16'd300, 16'h8000, 16'h001F, 1'b0, 1'b1);
    wait_drain();
    chk_eq("err_sticky", {31'h0, o_err}, 32'h1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    chk_eq("err_clr", {31'h0, o_err}, 32'h0);
    send_word(16'hF123, 1'b0);
    chk_eq("err_op_f", {31'h0, o_err}, 32'h1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;

    // Gapped LINE, then two back-to-back commands.
    send_draw(4'd2, 16'd100, 16'd20, 16'd40, 16'hFFF6, 16'hF800, 1'b1, 1'b1);
    wait_drain();
    send_draw(4'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'h0005, 1'b0, 1'b1);
    send_draw(4'd3, 16'hFFFF, 16'h7FFF, 16'h0010, 16'h0020, 16'hABCD, 1'b0, 1'b1);
    wait_drain();

    // Stall inside a partial LINE.
    send_word(16'h2000, 1'b0);
    send_word(16'd5, 1'b0);
`ifdef GS_CMD_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk_eq("tmo_early_err", {31'h0, o_err}, 32'h0);
    @(negedge clk);
    chk_eq("tmo_abort_err", {31'h0, o_err}, 32'h1);
    chk_eq("tmo_idle_ready", {31'h0, o_ready}, 32'h1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    send_draw(4'd2, 16'd7, 16'd8, 16'd9, 16'd10, 16'h1234, 1'b0, 1'b1);
    wait_drain();
`else
    repeat (20) @(negedge clk);
    chk_eq("stall_err", {31'h0, o_err}, 32'h0);
    chk_eq("stall_ready", {31'h0, o_ready}, 32'h1);
    begin
      exp_t ex;
      send_word(16'd8, 1'b0);
      send_word(16'd9, 1'b0);
      send_word(16'd10, 1'b0);
      send_word(16'h1234, 1'b0);
      ex.fill = 1'b0;
      ex.x1 = 16'd5; ex.y1 = 16'd8; ex.x2 = 16'd9; ex.y2 = 16'd10; ex.c = 16'h1234;
      ex.at = last_acc + 1;
      sb.push_back(ex);
    end
    wait_drain();
`endif

    // Reset in the middle of a SET_FB.
    send_word(16'h1000, 1'b0);
    send_word(16'h00AB, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("midrst_ready", {31'h0, o_ready}, 32'h1);
    send_draw(4'd2, 16'd11, 16'd12, 16'd13, 16'd14, 16'h0F0F, 1'b0, 1'b1);
    wait_drain();
    chk_eq("midrst_fb_w_kept", {22'h0, o_fb_width}, 32'd640);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
`default_nettype wire
